color_bbox_detect: RTL and testbench
====================================

# color_bbox_detect

Per-frame colour-blob bounding-box extractor for the object tracker. It sits directly downstream of the video generator / camera front end and consumes its vsync/hsync/data_valid/RGB stream, one pixel per clock on the channel-0 bus. Each pixel is tested against a programmable RGB window, and the min/max column and row of matching pixels are tracked. At every frame boundary it publishes the box, the match count and a frame-error flag.

## Interface
- HOR_RESOLUTION, 1366: expected active pixels per line; width check, max 4095.
- VER_RESOLUTION, 768: expected active lines per frame; height check, max 4095.
- HSYNC_POL, "NEGATIVE": hsync polarity, "NEGATIVE" or "POSITIVE". Passed through for consistency; not used for counting.
- VSYNC_POL, "NEGATIVE": vsync polarity, "NEGATIVE" or "POSITIVE".
- MIN_PIXELS, 16: minimum match count for bbox_valid_o.

Ports:
- pixel_clock_i  in  1  pixel clock. This is the block's only clock.
- rst_i  in  1  reset, synchronous, active-high.
- vsync_i, hsync_i, data_valid_i  in  1 each  video timing from the upstream generator.
- data_r_i, data_g_i, data_b_i  in  8 each  pixel channels. Connect to the generator's data0 outputs.
- r_min_i, r_max_i, g_min_i, g_max_i, b_min_i, b_max_i  in  8 each  inclusive colour window.
- bbox_x_min_o, bbox_x_max_o, bbox_y_min_o, bbox_y_max_o  out  12 each  box of the last completed frame, 0-based.
- pix_cnt_o  out  22  matching-pixel count of the last completed frame.
- bbox_valid_o  out  1  set when pix_cnt_o >= MIN_PIXELS.
- frame_err_o  out  1  last completed frame had a line-width or line-count mismatch.
- frame_done_o  out  1  one-cycle pulse when the outputs above update.

## Operation
- Input stage: vsync_i, data_valid_i and RGB are registered once into stage S1. vsync is normalised to active-high (vs_act) according to VSYNC_POL.
- Frame edge (FE): vs_act is 1 in S1 and was 0 in the previous S1 sample.
- States:
  - IDLE: entered on reset. Discards the partial frame. On FE, goes to ACTIVE and clears the accumulators; frame_done_o is not pulsed on this first FE.
  - ACTIVE: accumulates pixels. On each FE it publishes results, pulses frame_done_o, clears the accumulators and stays in ACTIVE.
- Window latch: the six window inputs are latched at every FE. Changes made mid-frame take effect from the next frame.
- Counters:
  - x counts S1 data_valid cycles within a line, starting at 0, and saturates at 4095.
  - A data_valid falling edge in S1 ends a line. At that point y increments and x returns to 0.
  - y saturates at 4095.
  - FE clears both x and y.
- Match: S1 data_valid=1 and, for each of R, G, B, min <= value <= max. If min > max for any channel, nothing matches.
- On match:
  - pix_cnt increments, saturating at 2^22-1.
  - On the first match of the frame, x_min=x_max=x and y_min=y_max=y.
  - On later matches, min/max are updated with x and y.
- Error flag:
  - A line whose length at line end is not HOR_RESOLUTION sets the frame's err flag.
  - At FE, the err flag is also set if the line count is not VER_RESOLUTION.
- Publish at FE:
  - All outputs are copied from the accumulators.
  - If no pixel matched, all four bbox outputs are 0, pix_cnt_o=0 and bbox_valid_o=0.
- Simultaneous events:
  - If S1 data_valid coincides with FE, the accumulators are cleared and that pixel counts as pixel (0,0) of the new frame.
  - If a line end coincides with FE, FE wins.
- Reset:
  - All outputs go to 0 and the window latches go to 0.
  - Reset returns the block to IDLE from any state, including mid-frame.

## Timing
- Pixel latency: a pixel sampled at edge k is accumulated at edge k+1.
- Publish latency: vsync_i reaches its active level at edge k. Outputs update and frame_done_o=1 at edge k+1; frame_done_o returns to 0 at edge k+2.
- Output hold: outputs stay stable between frame_done_o pulses.
- Throughput: one pixel per clock, no backpressure.
- Reset values: frame_done_o=0, bbox_*=0, pix_cnt_o=0, bbox_valid_o=0, frame_err_o=0.

## Test plan
All scenarios use HOR=16, VER=8, MIN_PIXELS=4, NEGATIVE polarity and window R 200..255, G 0..50, B 0..50 unless stated.
- **First-frame discard:** reset, then 3 frames in which a red 3x2 block sits at x=5..7, y=2..3. Required: no pulse at the first FE. Second and third pulses each give x 5..7, y 2..3, pix_cnt_o=6, bbox_valid_o=1, frame_err_o=0.
- **No match / below threshold:** an all-blue frame gives all bbox outputs 0, pix_cnt_o=0 and bbox_valid_o=0. A single red pixel at (15,7) gives x_min=x_max=15, y_min=y_max=7, pix_cnt_o=1 and bbox_valid_o=0.
- **Window edges:** pixels at R=200 and R=199 (G=B=0). Required: only the R=200 pixel is counted. Setting r_min_i=250, r_max_i=100 gives pix_cnt_o=0.
- **Mid-frame window change:** change the window while a frame is active. Required: that frame's result uses the old window and the following frame uses the new one.
- **Geometry error:** one line with 15 valid pixels gives frame_err_o=1. A frame with only 7 lines also gives frame_err_o=1. The next clean frame gives frame_err_o=0.
- **Reset mid-frame:** assert rst_i for 1 cycle at line 4. Required: outputs are 0 on the next edge, there is no pulse at the next FE, and the frame after that reports correctly.

Source files
------------

// File: rtl/color_bbox_detect.sv
// color_bbox_detect: per-frame RGB-window blob bounding-box extractor.
// Tracks min/max column/row of matching pixels and publishes them at each vsync.
module color_bbox_detect #(
  parameter int    HOR_RESOLUTION = 1366,
  parameter int    VER_RESOLUTION = 768,
  parameter string HSYNC_POL      = "NEGATIVE",
  parameter string VSYNC_POL      = "NEGATIVE",
  parameter int    MIN_PIXELS     = 16
) (
  input  logic        pixel_clock_i,
  input  logic        rst_i,
  input  logic        vsync_i,
  input  logic        hsync_i,
  input  logic        data_valid_i,
  input  logic [7:0]  data_r_i,
  input  logic [7:0]  data_g_i,
  input  logic [7:0]  data_b_i,
  input  logic [7:0]  r_min_i,
  input  logic [7:0]  r_max_i,
  input  logic [7:0]  g_min_i,
  input  logic [7:0]  g_max_i,
  input  logic [7:0]  b_min_i,
  input  logic [7:0]  b_max_i,
  output logic [11:0] bbox_x_min_o,
  output logic [11:0] bbox_x_max_o,
  output logic [11:0] bbox_y_min_o,
  output logic [11:0] bbox_y_max_o,
  output logic [21:0] pix_cnt_o,
  output logic        bbox_valid_o,
  output logic        frame_err_o,
  output logic        frame_done_o
);

  localparam logic [11:0] HOR_W   = 12'(HOR_RESOLUTION);
  localparam logic [11:0] VER_W   = 12'(VER_RESOLUTION);
  localparam logic [21:0] MIN_W   = 22'(MIN_PIXELS);
  localparam logic [11:0] XY_MAX  = 12'hFFF;
  localparam logic [21:0] CNT_MAX = 22'h3FFFFF;
  localparam bit          VS_POS  = (VSYNC_POL == "POSITIVE");
  localparam bit          HS_POS  = (HSYNC_POL == "POSITIVE");

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } state_t;

  state_t      r_state;

  // S1 input stage
  logic        r_vs_s1;
  logic        r_vs_d;
  logic        r_dv_s1;
  logic        r_dv_d;
  logic [7:0]  r_r_s1;
  logic [7:0]  r_g_s1;
  logic [7:0]  r_b_s1;

  logic [7:0]  r_rmin;
  logic [7:0]  r_rmax;
  logic [7:0]  r_gmin;
  logic [7:0]  r_gmax;
  logic [7:0]  r_bmin;
  logic [7:0]  r_bmax;

  logic [11:0] r_x;
  logic [11:0] r_y;
  logic [11:0] r_x0;
  logic [11:0] r_x1;
  logic [11:0] r_y0;
  logic [11:0] r_y1;
  logic [21:0] r_cnt;
  logic        r_any;
  logic        r_err;

  logic        w_vs_act;
  logic        w_fe;
  logic        w_line_end;
  logic        w_match;
  logic [7:0]  w_rmin;
  logic [7:0]  w_rmax;
  logic [7:0]  w_gmin;
  logic [7:0]  w_gmax;
  logic [7:0]  w_bmin;
  logic [7:0]  w_bmax;
  logic        w_unused_hs;

  // hsync is accepted for interface symmetry only
  assign w_unused_hs = hsync_i ^ HS_POS;

  assign w_vs_act   = VS_POS ? vsync_i : ~vsync_i;
  assign w_fe       = r_vs_s1 & ~r_vs_d;
  assign w_line_end = r_dv_d & ~r_dv_s1;

  // A pixel coincident with FE belongs to the new frame and its window
  assign w_rmin = w_fe ? r_min_i : r_rmin;
  assign w_rmax = w_fe ? r_max_i : r_rmax;
  assign w_gmin = w_fe ? g_min_i : r_gmin;
  assign w_gmax = w_fe ? g_max_i : r_gmax;
  assign w_bmin = w_fe ? b_min_i : r_bmin;
  assign w_bmax = w_fe ? b_max_i : r_bmax;

  assign w_match = r_dv_s1 &&
    (r_r_s1 >= w_rmin) && (r_r_s1 <= w_rmax) &&
    (r_g_s1 >= w_gmin) && (r_g_s1 <= w_gmax) &&
    (r_b_s1 >= w_bmin) && (r_b_s1 <= w_bmax);

  always_ff @(posedge pixel_clock_i) begin
    if (rst_i) begin
      r_vs_s1 <= 1'b0;
      r_vs_d  <= 1'b0;
      r_dv_s1 <= 1'b0;
      r_dv_d  <= 1'b0;
      r_r_s1  <= '0;
      r_g_s1  <= '0;
      r_b_s1  <= '0;
    end else begin
      r_vs_s1 <= w_vs_act;
      r_vs_d  <= r_vs_s1;
      r_dv_s1 <= data_valid_i;
      r_dv_d  <= r_dv_s1;
      r_r_s1  <= data_r_i;
      r_g_s1  <= data_g_i;
      r_b_s1  <= data_b_i;
    end
  end

  always_ff @(posedge pixel_clock_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_rmin       <= '0;
      r_rmax       <= '0;
      r_gmin       <= '0;
      r_gmax       <= '0;
      r_bmin       <= '0;
      r_bmax       <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_x0         <= '0;
      r_x1         <= '0;
      r_y0         <= '0;
      r_y1         <= '0;
      r_cnt        <= '0;
      r_any        <= 1'b0;
      r_err        <= 1'b0;
      bbox_x_min_o <= '0;
      bbox_x_max_o <= '0;
      bbox_y_min_o <= '0;
      bbox_y_max_o <= '0;
      pix_cnt_o    <= '0;
      bbox_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (w_fe) begin
        r_rmin <= r_min_i;
        r_rmax <= r_max_i;
        r_gmin <= g_min_i;
        r_gmax <= g_max_i;
        r_bmin <= b_min_i;
        r_bmax <= b_max_i;
        if (r_state == ST_ACTIVE) begin
          bbox_x_min_o <= r_x0;
          bbox_x_max_o <= r_x1;
          bbox_y_min_o <= r_y0;
          bbox_y_max_o <= r_y1;
          pix_cnt_o    <= r_cnt;
          bbox_valid_o <= r_any && (r_cnt >= MIN_W);
          frame_err_o  <= r_err || (r_y != VER_W);
          frame_done_o <= 1'b1;
        end
        r_state <= ST_ACTIVE;
        r_x     <= r_dv_s1 ? 12'd1 : 12'd0;
        r_y     <= '0;
        r_x0    <= '0;
        r_x1    <= '0;
        r_y0    <= '0;
        r_y1    <= '0;
        r_cnt   <= {21'd0, w_match};
        r_any   <= w_match;
        r_err   <= 1'b0;
      end else if (r_dv_s1) begin
        if (r_x != XY_MAX) r_x <= r_x + 12'd1;
        if (w_match) begin
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 22'd1;
          r_any <= 1'b1;
          if (!r_any) begin
            r_x0 <= r_x;
            r_x1 <= r_x;
            r_y0 <= r_y;
            r_y1 <= r_y;
          end else begin
            if (r_x < r_x0) r_x0 <= r_x;
            if (r_x > r_x1) r_x1 <= r_x;
            if (r_y < r_y0) r_y0 <= r_y;
            if (r_y > r_y1) r_y1 <= r_y;
          end
        end
      end else if (w_line_end) begin
        r_x <= '0;
        if (r_y != XY_MAX) r_y <= r_y + 12'd1;
        if (r_x != HOR_W) r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_color_bbox_detect.sv
// tb_color_bbox_detect: directed + randomized frames vs an image-level model.
// Each frame is held as a pixel array; the model scans it to predict results.
module tb_color_bbox_detect;

  localparam int HOR = 16;
  localparam int VER = 8;
  localparam int MINP = 4;

  typedef struct {
    logic [11:0] x0, x1, y0, y1;
    logic [21:0] cnt;
    logic        vld, err;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        vsync_i = 1'b1, hsync_i = 1'b1, dv_i = 1'b0;
  logic [7:0]  dr = 0, dg = 0, db = 0;
  logic [7:0]  rmin = 200, rmax = 255, gmin = 0, gmax = 50;
  logic [7:0]  bmin = 0, bmax = 50;
  logic [11:0] x0_o, x1_o, y0_o, y1_o;
  logic [21:0] cnt_o;
  logic        vld_o, err_o, done_o;

  logic [7:0] fr_r [VER][HOR];
  logic [7:0] fr_g [VER][HOR];
  logic [7:0] fr_b [VER][HOR];
  int ll [VER];
  int nl;

  int n_checks = 0, n_fail = 0;
  int n_pulses = 0, exp_pulses = 0;
  bit exp_valid = 0;
  res_t exp_r;

  always #5 clk = ~clk;

  color_bbox_detect #(
    .HOR_RESOLUTION(HOR), .VER_RESOLUTION(VER),
    .HSYNC_POL("NEGATIVE"), .VSYNC_POL("NEGATIVE"),
    .MIN_PIXELS(MINP)
  ) dut (
    .pixel_clock_i(clk), .rst_i(rst_i),
    .vsync_i(vsync_i), .hsync_i(hsync_i), .data_valid_i(dv_i),
    .data_r_i(dr), .data_g_i(dg), .data_b_i(db),
    .r_min_i(rmin), .r_max_i(rmax), .g_min_i(gmin),
    .g_max_i(gmax), .b_min_i(bmin), .b_max_i(bmax),
    .bbox_x_min_o(x0_o), .bbox_x_max_o(x1_o),
    .bbox_y_min_o(y0_o), .bbox_y_max_o(y1_o),
    .pix_cnt_o(cnt_o), .bbox_valid_o(vld_o),
    .frame_err_o(err_o), .frame_done_o(done_o)
  );

  always @(posedge clk) if (done_o) n_pulses++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model_frame(input logic [7:0] rl, rh, gl,
                                       gh, bl, bh);
    res_t e;
    bit any = 0;
    int c = 0;
    e = '{default: '0};
    e.err = (nl != VER);
    for (int y = 0; y < nl; y++) begin
      if (ll[y] != HOR) e.err = 1'b1;
      for (int x = 0; x < ll[y]; x++) begin
        if (fr_r[y][x] >= rl && fr_r[y][x] <= rh &&
            fr_g[y][x] >= gl && fr_g[y][x] <= gh &&
            fr_b[y][x] >= bl && fr_b[y][x] <= bh) begin
          if (!any) begin
            e.x0 = 12'(x); e.x1 = 12'(x);
            e.y0 = 12'(y); e.y1 = 12'(y);
          end else begin
            if (x < int'(e.x0)) e.x0 = 12'(x);
            if (x > int'(e.x1)) e.x1 = 12'(x);
            if (y < int'(e.y0)) e.y0 = 12'(y);
            if (y > int'(e.y1)) e.y1 = 12'(y);
          end
          any = 1;
          c++;
        end
      end
    end
    e.cnt = 22'(c);
    e.vld = (c >= MINP);
    return e;
  endfunction

  task automatic clear_frame();
    nl = VER;
    for (int y = 0; y < VER; y++) begin
      ll[y] = HOR;
      for (int x = 0; x < HOR; x++) begin
        fr_r[y][x] = 0; fr_g[y][x] = 0; fr_b[y][x] = 255;
      end
    end
  endtask

  task automatic put(input int x, input int y, input logic [7:0] r,
                     input logic [7:0] g, input logic [7:0] b);
    fr_r[y][x] = r; fr_g[y][x] = g; fr_b[y][x] = b;
  endtask

  task automatic set_win(input logic [7:0] a, b, c, d, e, f);
    rmin = a; rmax = b; gmin = c; gmax = d; bmin = e; bmax = f;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x0"}, 32'(x0_o), 0);
    chk({tag, "_x1"}, 32'(x1_o), 0);
    chk({tag, "_y0"}, 32'(y0_o), 0);
    chk({tag, "_y1"}, 32'(y1_o), 0);
    chk({tag, "_cnt"}, 32'(cnt_o), 0);
    chk({tag, "_vld"}, 32'(vld_o), 0);
    chk({tag, "_err"}, 32'(err_o), 0);
    chk({tag, "_done"}, 32'(done_o), 0);
  endtask

  // Frame start; checks the publish of the previously sent frame
  task automatic do_vsync();
    int pos = -1;
    res_t got = '{default: '0};
    @(negedge clk);
    vsync_i = 1'b0; dv_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done_o && pos < 0) pos = i;
      if (i == 1) begin
        got.x0 = x0_o; got.x1 = x1_o; got.y0 = y0_o; got.y1 = y1_o;
        got.cnt = cnt_o; got.vld = vld_o; got.err = err_o;
      end
    end
    if (exp_valid) begin
      exp_pulses++;
      chk("done_pos", 32'(pos), 1);
      chk("x_min", 32'(got.x0), 32'(exp_r.x0));
      chk("x_max", 32'(got.x1), 32'(exp_r.x1));
      chk("y_min", 32'(got.y0), 32'(exp_r.y0));
      chk("y_max", 32'(got.y1), 32'(exp_r.y1));
      chk("pix_cnt", 32'(got.cnt), 32'(exp_r.cnt));
      chk("valid", 32'(got.vld), 32'(exp_r.vld));
      chk("err", 32'(got.err), 32'(exp_r.err));
    end else begin
      chk("no_pulse", 32'(pos), 32'hFFFFFFFF);
    end
    @(negedge clk);
    vsync_i = 1'b1;
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dv_i = 1'b0; hsync_i = 1'b0;
      dr = 8'd230; dg = 8'd10; db = 8'd10;
    end
  endtask

  task automatic run_frame(input bit rst_mid, input bit chg,
                           input logic [7:0] nrl, input logic [7:0] nrh);
    do_vsync();
    exp_r = model_frame(rmin, rmax, gmin, gmax, bmin, bmax);
    blank(2);
    for (int y = 0; y < nl; y++) begin
      if (y == 4 && chg) begin rmin = nrl; rmax = nrh; end
      blank(3);
      if (y == 4 && rst_mid) begin
        @(negedge clk); rst_i = 1'b1;
        @(posedge clk); #1;
        chk_zero("rst_mid");
        @(negedge clk); rst_i = 1'b0;
      end
      for (int x = 0; x < ll[y]; x++) begin
        @(negedge clk);
        hsync_i = 1'b1; dv_i = 1'b1;
        dr = fr_r[y][x]; dg = fr_g[y][x]; db = fr_b[y][x];
      end
    end
    blank(3);
    exp_valid = !rst_mid;
  endtask

  task automatic red_block();
    clear_frame();
    for (int y = 2; y <= 3; y++)
      for (int x = 5; x <= 7; x++) put(x, y, 8'd240, 8'd20, 8'd30);
  endtask

  initial begin
    clear_frame();
    repeat (4) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk); rst_i = 1'b0;

    red_block();
    repeat (3) run_frame(0, 0, 0, 0);

    clear_frame();
    run_frame(0, 0, 0, 0);
    put(15, 7, 8'd255, 8'd0, 8'd0);
    run_frame(0, 0, 0, 0);

    clear_frame();
    put(3, 1, 8'd200, 8'd0, 8'd0);
    put(9, 4, 8'd199, 8'd0, 8'd0);
    run_frame(0, 0, 0, 0);
    set_win(250, 100, 0, 50, 0, 50);
    red_block();
    run_frame(0, 0, 0, 0);
    set_win(200, 255, 0, 50, 0, 50);

    clear_frame();
    for (int y = 1; y <= 6; y++)
      for (int x = 2; x <= 12; x++) put(x, y, 8'd220, 8'd5, 8'd5);
    run_frame(0, 1, 8'd230, 8'd255);
    run_frame(0, 0, 0, 0);
    set_win(200, 255, 0, 50, 0, 50);

    red_block();
    ll[3] = 15;
    run_frame(0, 0, 0, 0);
    red_block();
    nl = 7;
    run_frame(0, 0, 0, 0);
    red_block();
    run_frame(0, 0, 0, 0);

    for (int f = 0; f < 8; f++) begin
      clear_frame();
      for (int y = 0; y < VER; y++)
        for (int x = 0; x < HOR; x++)
          if ($urandom_range(0, 3) == 0)
            put(x, y, 8'($urandom_range(190, 255)),
                8'($urandom_range(0, 60)), 8'($urandom_range(0, 60)));
          else
            put(x, y, 8'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) ll[$urandom_range(0, VER-1)] =
        $urandom_range(13, 15);
      if ($urandom_range(0, 4) == 0) nl = 7;
      if (f % 3 == 2)
        set_win(8'($urandom_range(150, 220)), 8'($urandom_range(190, 255)),
                8'($urandom_range(0, 20)), 8'($urandom_range(10, 70)),
                8'($urandom_range(0, 20)), 8'($urandom_range(10, 70)));
      else
        set_win(200, 255, 0, 50, 0, 50);
      run_frame(0, 0, 0, 0);
    end
    set_win(200, 255, 0, 50, 0, 50);

    red_block();
    run_frame(0, 0, 0, 0);
    run_frame(1, 0, 0, 0);
    run_frame(0, 0, 0, 0);
    run_frame(0, 0, 0, 0);
    do_vsync();
    blank(4);

    chk("pulses", 32'(n_pulses), 32'(exp_pulses));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
